ac97_play_ctrl: RTL and testbench
=================================

AC97_PLAY_CTRL -- requirements
Module: ac97_play_ctrl

Interface
REQ-001 Parameters: ALRIGHT_LEN, default 76194, byte length of song 0; COOL_LEN, default 90384, byte length of song 1.
REQ-002 AUDIO_BIT_CLK  in  1  codec bit clock (12.288 MHz); sole clock; all state changes on its rising edge.
REQ-003 RESET_B  in  1  asynchronous, active-low reset.
REQ-004 AUDIO_SDATA_IN  in  1  codec serial data; only the codec-ready bit is used.
REQ-005 GPIO_SW_W  in  1  asynchronous button, play song 1 ("cool").
REQ-006 GPIO_SW_E  in  1  asynchronous button, play song 0 ("alright").
REQ-007 mem_data  in  16  sample from song memory; [7:0] = byte at mem_addr, [15:8] = byte at mem_addr+1; combinational.
REQ-008 mem_addr  out  18  byte address into song memory; even; stable for a whole frame.
REQ-009 mem_sel  out  1  song select to memory; 1 = cool, 0 = alright.
REQ-010 AUDIO_SYNC  out  1  AC97 frame sync, registered.
REQ-011 AUDIO_SDATA_OUT  out  1  AC97 serial frame data, registered, MSB first.
REQ-012 playing  out  1  high while state is PLAY.

Function
REQ-013 Frame position counter pos: 0..255, +1 per clock, wraps 255 to 0; outputs show frame bit pos.
REQ-014 AUDIO_SYNC SHALL be 1 exactly for pos 0..15, else 0.
REQ-015 Frame layout: tag 16 bits (bit15 frame valid=1, bit14 slot1, bit13 slot2, bit12 slot3, bit11 slot4 valid, rest 0), then slots 1..12 of 20 bits each; unused slots 0.
REQ-016 Frame content for the next frame SHALL be latched at pos 255 (the frame boundary); no mid-frame change.
REQ-017 codec_ready SHALL be captured from AUDIO_SDATA_IN on the edge where pos advances from 0 to 1.
REQ-018 States: INIT, IDLE, PLAY.
REQ-019 INIT: frames carry tag 16'h8000 until codec_ready=1; then three consecutive command frames (tag 16'hE000): reg 0x02<-0x0000, reg 0x04<-0x0000, reg 0x18<-0x0808; then IDLE.
REQ-020 Command slot format: slot1 = {1'b0 write, index[6:0], 12'b0}; slot2 = {data[15:0], 4'b0}.
REQ-021 IDLE: frames carry tag 16'h8000; mem_addr=0.
REQ-022 Buttons: 2-flop synchronised, rising-edge detected, held as pending until the next frame boundary; both pending together -> cool wins.
REQ-023 Pending request at a boundary in IDLE or PLAY: mem_sel<-request, mem_addr<-0, state PLAY, and the latched frame is silence (tag 16'h9800, slots 3/4 zero); pending cleared.
REQ-024 Pending request during INIT SHALL stay pending until INIT completes.
REQ-025 PLAY boundary without a request: slot3 = slot4 = {mem_data, 4'b0}, tag 16'h9800; then mem_addr+=2.
REQ-026 End of song: if mem_addr+2 >= length(mem_sel) at that boundary, the sample is still sent, mem_addr<-0, state IDLE.
REQ-027 Length is selected by mem_sel: 1 -> COOL_LEN, 0 -> ALRIGHT_LEN.

Reset
REQ-028 While RESET_B=0, the following SHALL hold: AUDIO_SYNC=0, AUDIO_SDATA_OUT=0, mem_addr=0, mem_sel=0, playing=0, pos=255, state INIT, pending and synchronisers cleared, codec_ready=0.
REQ-029 Reset assertion mid-frame SHALL take effect immediately; the first edge after release starts frame pos 0 with tag 16'h8000.

Structure
REQ-030 Package ac97_pkg: state enum, slot/tag widths, tag constants (8000/E000/9800), codec register indices and init command table, default song lengths.
REQ-031 One sub-module, ac97_frame_ser: pos counter, 256-bit load/shift register, SYNC generation, codec_ready capture.

Verification
REQ-032 Reset, codec_ready held 0 for 4 frames -> each frame tag 16'h8000, SYNC high exactly for pos 0..15.
REQ-033 codec_ready=1 -> next 3 frames: slot1/slot2 = 20'h02000/20'h00000, 20'h04000/20'h00000, 20'h18000/20'h08080, tag 16'hE000; then tag 16'h8000.
REQ-034 IDLE, pulse GPIO_SW_E, memory returns 16'h1234 at addr 0 -> one silent 9800 frame, then slots 3/4 = 20'h12340, mem_addr=2, playing=1.
REQ-035 Play alright to end -> 38097 sample frames; after the addr-76192 frame: playing=0, mem_addr=0.
REQ-036 During PLAY, both buttons rise in one cycle -> at next boundary mem_sel=1, mem_addr=0, silent frame.
REQ-037 RESET_B low at pos 100 during PLAY -> outputs 0 immediately; after release INIT restarts.

Source files
------------

// File: rtl/ac97_pkg.sv
// Shared definitions for the AC97 song player: controller states, frame
// geometry, tag words, codec init commands and default song lengths.
package ac97_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    // Frame geometry: 16-bit tag followed by twelve 20-bit slots
    localparam int TAG_W     = 16;
    localparam int SLOT_W    = 20;
    localparam int NUM_SLOTS = 12;
    localparam int FRAME_W   = TAG_W + NUM_SLOTS * SLOT_W;
    localparam int POS_W     = 8;
    localparam int SYNC_LEN  = 16;

    // Tag words: frame valid only; valid+slot1+slot2; valid+slot3+slot4
    localparam logic [TAG_W-1:0] TAG_IDLE = 16'h8000;
    localparam logic [TAG_W-1:0] TAG_CMD  = 16'hE000;
    localparam logic [TAG_W-1:0] TAG_PCM  = 16'h9800;

    // Codec registers touched during initialisation
    localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
    localparam logic [6:0] REG_HP_VOL      = 7'h04;
    localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;

    localparam int NUM_INIT_CMDS = 3;

    localparam int ALRIGHT_LEN_DEF = 76194;
    localparam int COOL_LEN_DEF    = 90384;

    typedef struct packed {
        logic [6:0]  index;
        logic [15:0] data;
    } codec_cmd_t;

    // Init command table: unmute master and headphone, set PCM out gain
    function automatic codec_cmd_t init_cmd(input logic [1:0] idx);
        codec_cmd_t c;
        case (idx)
            2'd0:    c = '{index: REG_MASTER_VOL,  data: 16'h0000};
            2'd1:    c = '{index: REG_HP_VOL,      data: 16'h0000};
            default: c = '{index: REG_PCM_OUT_VOL, data: 16'h0808};
        endcase
        return c;
    endfunction

    // Slot 1 carries a write (bit 19 = 0) to the register index
    function automatic logic [SLOT_W-1:0] cmd_slot1(input codec_cmd_t c);
        return {1'b0, c.index, 12'b0};
    endfunction

    // Slot 2 carries the 16-bit register data, left justified
    function automatic logic [SLOT_W-1:0] cmd_slot2(input codec_cmd_t c);
        return {c.data, 4'b0};
    endfunction

    // Assemble a full frame; slots 5..12 are never used and stay zero
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [TAG_W-1:0]  tag,
        input logic [SLOT_W-1:0] s1,
        input logic [SLOT_W-1:0] s2,
        input logic [SLOT_W-1:0] s3,
        input logic [SLOT_W-1:0] s4
    );
        return {tag, s1, s2, s3, s4, {(FRAME_W - TAG_W - 4 * SLOT_W){1'b0}}};
    endfunction

endpackage

// File: rtl/ac97_frame_ser.sv
// AC97 frame serialiser: free-running bit position, frame load at the
// boundary, MSB-first shift-out, SYNC generation and codec-ready capture.
module ac97_frame_ser
    import ac97_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               sdata_i,
    output logic               boundary_o,
    output logic               codec_ready_o,
    output logic               sync_o,
    output logic               sdata_o
);

    logic [POS_W-1:0]   pos_q;
    logic [FRAME_W-1:0] shift_q;
    logic               sync_q;
    logic               sdata_q;
    logic               codec_ready_q;

    // The last bit of a frame is the point where the next frame is taken in
    assign boundary_o = (pos_q == '1);

    // Advance position; load the new frame at the boundary, otherwise shift
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            pos_q   <= '1;
            shift_q <= '0;
            sync_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            pos_q <= pos_q + 1'b1;
            if (boundary_o) begin
                shift_q <= {frame_i[FRAME_W-2:0], 1'b0};
                sdata_q <= frame_i[FRAME_W-1];
                sync_q  <= 1'b1;
            end else begin
                shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
                sdata_q <= shift_q[FRAME_W-1];
                sync_q  <= (pos_q < POS_W'(SYNC_LEN - 1));
            end
        end
    end

    // Codec-ready is the first bit of the incoming tag, sampled leaving pos 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codec_ready_q <= 1'b0;
        end else if (pos_q == '0) begin
            codec_ready_q <= sdata_i;
        end
    end

    assign codec_ready_o = codec_ready_q;
    assign sync_o        = sync_q;
    assign sdata_o       = sdata_q;

endmodule

// File: rtl/ac97_play_ctrl.sv
// AC97 song player: initialises the codec, then streams 16-bit samples from
// song memory to the left/right PCM slots on button request.
module ac97_play_ctrl
    import ac97_pkg::*;
#(
    parameter int ALRIGHT_LEN = ALRIGHT_LEN_DEF,
    parameter int COOL_LEN    = COOL_LEN_DEF
) (
    input  logic        AUDIO_BIT_CLK,
    input  logic        RESET_B,
    input  logic        AUDIO_SDATA_IN,
    input  logic        GPIO_SW_W,
    input  logic        GPIO_SW_E,
    input  logic [15:0] mem_data,
    output logic [17:0] mem_addr,
    output logic        mem_sel,
    output logic        AUDIO_SYNC,
    output logic        AUDIO_SDATA_OUT,
    output logic        playing
);

    state_e             state_q;
    logic [17:0]        mem_addr_q;
    logic               mem_sel_q;
    logic [1:0]         init_idx_q;
    logic [2:0]         sw_w_q;
    logic [2:0]         sw_e_q;
    logic               pend_w_q;
    logic               pend_e_q;

    logic               boundary;
    logic               codec_ready;
    logic [FRAME_W-1:0] frame_d;
    logic               have_req;
    logic               init_go;
    logic               consume;
    logic               rise_w;
    logic               rise_e;
    logic [31:0]        song_len;
    logic [31:0]        addr_plus2;
    logic               song_done;
    logic [SLOT_W-1:0]  pcm_slot;
    codec_cmd_t         cmd;

    ac97_frame_ser u_frame_ser (
        .clk           (AUDIO_BIT_CLK),
        .rst_n         (RESET_B),
        .frame_i       (frame_d),
        .sdata_i       (AUDIO_SDATA_IN),
        .boundary_o    (boundary),
        .codec_ready_o (codec_ready),
        .sync_o        (AUDIO_SYNC),
        .sdata_o       (AUDIO_SDATA_OUT)
    );

    assign rise_w     = sw_w_q[1] & ~sw_w_q[2];
    assign rise_e     = sw_e_q[1] & ~sw_e_q[2];
    assign have_req   = pend_w_q | pend_e_q;
    assign init_go    = codec_ready | (init_idx_q != 2'd0);
    assign consume    = boundary & have_req & (state_q != ST_INIT);
    assign song_len   = mem_sel_q ? 32'(COOL_LEN) : 32'(ALRIGHT_LEN);
    assign addr_plus2 = {14'd0, mem_addr_q} + 32'd2;
    assign song_done  = (addr_plus2 >= song_len);
    assign pcm_slot   = {mem_data, 4'b0};
    assign cmd        = init_cmd(init_idx_q);

    // Two-flop synchronisers plus one history flop for rising-edge detection
    always_ff @(posedge AUDIO_BIT_CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            sw_w_q <= '0;
            sw_e_q <= '0;
        end else begin
            sw_w_q <= {sw_w_q[1:0], GPIO_SW_W};
            sw_e_q <= {sw_e_q[1:0], GPIO_SW_E};
        end
    end

    // Requests stay pending until a boundary outside INIT acts on them
    always_ff @(posedge AUDIO_BIT_CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            pend_w_q <= 1'b0;
            pend_e_q <= 1'b0;
        end else begin
            pend_w_q <= (pend_w_q & ~consume) | rise_w;
            pend_e_q <= (pend_e_q & ~consume) | rise_e;
        end
    end

    // Content of the next frame, decided from the state seen at the boundary
    always_comb begin
        // NOTE: default first so every path assigns frame_d and no latch forms.
        frame_d = pack_frame(TAG_IDLE, '0, '0, '0, '0);
        case (state_q)
            ST_INIT: begin
                if (init_go) begin
                    frame_d = pack_frame(TAG_CMD, cmd_slot1(cmd), cmd_slot2(cmd), '0, '0);
                end
            end
            ST_IDLE, ST_PLAY: begin
                if (have_req) begin
                    frame_d = pack_frame(TAG_PCM, '0, '0, '0, '0);
                end else if (state_q == ST_PLAY) begin
                    frame_d = pack_frame(TAG_PCM, '0, '0, pcm_slot, pcm_slot);
                end
            end
            default: ;
        endcase
    end

    // Player FSM: advances only at frame boundaries so a frame never changes
    always_ff @(posedge AUDIO_BIT_CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q    <= ST_INIT;
            mem_addr_q <= '0;
            mem_sel_q  <= 1'b0;
            init_idx_q <= 2'd0;
        end else if (boundary) begin
            case (state_q)
                ST_INIT: begin
                    if (init_go) begin
                        if (init_idx_q == 2'(NUM_INIT_CMDS - 1)) begin
                            init_idx_q <= 2'd0;
                            state_q    <= ST_IDLE;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                        end
                    end
                end
                ST_IDLE, ST_PLAY: begin
                    if (have_req) begin
                        mem_sel_q  <= pend_w_q;
                        mem_addr_q <= '0;
                        state_q    <= ST_PLAY;
                    end else if (state_q == ST_PLAY) begin
                        if (song_done) begin
                            mem_addr_q <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            mem_addr_q <= mem_addr_q + 18'd2;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_sel  = mem_sel_q;
    assign playing  = (state_q == ST_PLAY);

endmodule

// File: tb/tb_ac97_play_ctrl.sv
// Bench for ac97_play_ctrl: frame-level reference model feeds a scoreboard,
// a monitor deserialises each AC97 frame and compares it.
module tb_ac97_play_ctrl;

    localparam int A_LEN  = 20;
    localparam int C_LEN  = 27;
    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_PLAY = 2;

    logic        clk    = 1'b0;
    logic        rst_b  = 1'b0;
    logic        sdin   = 1'b0;
    logic        sw_w   = 1'b0;
    logic        sw_e   = 1'b0;
    logic [15:0] mem_data;
    logic [17:0] mem_addr;
    logic        mem_sel;
    logic        sync;
    logic        sdout;
    logic        playing;

    ac97_play_ctrl #(.ALRIGHT_LEN(A_LEN), .COOL_LEN(C_LEN)) dut (
        .AUDIO_BIT_CLK   (clk),
        .RESET_B         (rst_b),
        .AUDIO_SDATA_IN  (sdin),
        .GPIO_SW_W       (sw_w),
        .GPIO_SW_E       (sw_e),
        .mem_data        (mem_data),
        .mem_addr        (mem_addr),
        .mem_sel         (mem_sel),
        .AUDIO_SYNC      (sync),
        .AUDIO_SDATA_OUT (sdout),
        .playing         (playing)
    );

    always #5 clk = ~clk;

    // Song memory contents: alright starts with sample 16'h1234
    function automatic logic [7:0] song_byte(input logic sel, input logic [17:0] a);
        if (!sel && a == 18'd0) return 8'h34;
        if (!sel && a == 18'd1) return 8'h12;
        return 8'(a * 37 + (sel ? 101 : 0) + 11);
    endfunction

    assign mem_data = {song_byte(mem_sel, mem_addr + 18'd1), song_byte(mem_sel, mem_addr)};

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1;
        logic [19:0] s2;
        logic [19:0] s3;
        logic [19:0] s4;
        logic [17:0] addr;
        logic        sel;
        logic        play;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model, one step per frame
    logic [19:0] cmd_s1 [3] = '{20'h02000, 20'h04000, 20'h18000};
    logic [19:0] cmd_s2 [3] = '{20'h00000, 20'h00000, 20'h08080};
    int          m_st;
    int          m_cmds;
    int          m_addr;
    logic        m_sel;
    logic        m_pe;
    logic        m_pw;
    int          frames_sent;

    function automatic exp_t fill_status(input exp_t e);
        exp_t r = e;
        r.addr = 18'(m_addr);
        r.sel  = m_sel;
        r.play = (m_st == M_PLAY);
        return r;
    endfunction

    task automatic model_reset();
        exp_t e;
        m_st = M_INIT; m_cmds = 0; m_addr = 0; m_sel = 1'b0; m_pe = 1'b0; m_pw = 1'b0;
        e = '{tag: 16'h8000, s1: '0, s2: '0, s3: '0, s4: '0, addr: '0, sel: 1'b0, play: 1'b0};
        sb_q.push_back(fill_status(e));
        frames_sent++;
    endtask

    task automatic model_boundary(input logic codec);
        exp_t e;
        logic [15:0] smp;
        e = '{tag: 16'h8000, s1: '0, s2: '0, s3: '0, s4: '0, addr: '0, sel: 1'b0, play: 1'b0};
        if (m_st == M_INIT) begin
            if (m_cmds > 0 || codec) begin
                e.tag = 16'hE000;
                e.s1  = cmd_s1[m_cmds];
                e.s2  = cmd_s2[m_cmds];
                m_cmds++;
                if (m_cmds == 3) m_st = M_IDLE;
            end
        end else if (m_pw || m_pe) begin
            e.tag = 16'h9800;
            m_sel = m_pw;
            m_addr = 0;
            m_st = M_PLAY;
            m_pw = 1'b0;
            m_pe = 1'b0;
        end else if (m_st == M_PLAY) begin
            smp   = {song_byte(m_sel, 18'(m_addr + 1)), song_byte(m_sel, 18'(m_addr))};
            e.tag = 16'h9800;
            e.s3  = {smp, 4'h0};
            e.s4  = {smp, 4'h0};
            if (m_addr + 2 >= (m_sel ? C_LEN : A_LEN)) begin
                m_addr = 0;
                m_st = M_IDLE;
            end else begin
                m_addr += 2;
            end
        end
        sb_q.push_back(fill_status(e));
        frames_sent++;
    endtask

    // Monitor: deserialise each frame and compare with the scoreboard
    logic         mon_en = 1'b0;
    int           mon_pos = 0;
    int           sync_bad = 0;
    int           mon_frames = 0;
    logic [255:0] fbits;
    logic [17:0]  s_addr;
    logic         s_sel;
    logic         s_play;
    exp_t         mon_e;
    int           depth;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            fbits[255 - mon_pos] = sdout;
            if (sync !== (mon_pos < 16)) sync_bad++;
            if (mon_pos == 128) begin
                s_addr = mem_addr;
                s_sel  = mem_sel;
                s_play = playing;
            end
            if (mon_pos == 255) begin
                depth = sb_q.size();
                check("sb_has_entry", (depth > 0), 1'b1);
                if (depth > 0) begin
                    mon_e = sb_q.pop_front();
                    check("tag", fbits[255:240], mon_e.tag);
                    check("slot1", fbits[239:220], mon_e.s1);
                    check("slot2", fbits[219:200], mon_e.s2);
                    check("slot3", fbits[199:180], mon_e.s3);
                    check("slot4", fbits[179:160], mon_e.s4);
                    check("slots5_12", fbits[159:0], '0);
                    check("mem_addr", s_addr, mon_e.addr);
                    check("mem_sel", s_sel, mon_e.sel);
                    check("playing", s_play, mon_e.play);
                end
                check("sync_bits_wrong", sync_bad, 0);
                sync_bad = 0;
                mon_pos = 0;
                mon_frames++;
            end else begin
                mon_pos++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sync"}, sync, 1'b0);
        check({tag, "_sdata"}, sdout, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 18'd0);
        check({tag, "_mem_sel"}, mem_sel, 1'b0);
        check({tag, "_playing"}, playing, 1'b0);
    endtask

    // Hold reset a few cycles, release on a falling edge, rearm model/monitor
    task automatic reset_and_release();
        rst_b = 1'b0; mon_en = 1'b0; sb_q.delete();
        sw_e = 1'b0; sw_w = 1'b0; sdin = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_b = 1'b1;
        mon_pos = 0; sync_bad = 0; mon_en = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One frame of stimulus, entered on the falling edge during pos 0
    task automatic run_frame(input logic codec, input logic pe, input logic pw, input int ppos);
        sdin = codec;
        for (int p = 0; p < 256; p++) begin
            if ((pe || pw) && p == ppos) begin
                sw_e = pe;
                sw_w = pw;
            end
            if (p == ppos + 8) begin
                sw_e = 1'b0;
                sw_w = 1'b0;
            end
            @(negedge clk);
        end
        if (pe) m_pe = 1'b1;
        if (pw) m_pw = 1'b1;
        model_boundary(codec);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        frames_sent = 0;
        reset_and_release();

        // Codec not ready: plain 8000 frames
        repeat (4) run_frame(1'b0, 1'b0, 1'b0, 0);
        // Codec ready: three command frames, then idle
        repeat (5) run_frame(1'b1, 1'b0, 1'b0, 0);
        // Play alright to the end
        run_frame(1'b1, 1'b1, 1'b0, 50);
        repeat (12) run_frame(1'b1, 1'b0, 1'b0, 0);
        // Start alright, then both buttons at once switch to cool
        run_frame(1'b1, 1'b1, 1'b0, 120);
        repeat (3) run_frame(1'b1, 1'b0, 1'b0, 0);
        run_frame(1'b1, 1'b1, 1'b1, 77);
        repeat (16) run_frame(1'b1, 1'b0, 1'b0, 0);

        // Random button traffic
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 2);
                run_frame(1'b1, (r != 1), (r != 0), $urandom_range(20, 200));
            end else begin
                run_frame(1'b1, 1'b0, 1'b0, 0);
            end
        end

        // Reset at pos 100 while playing
        run_frame(1'b1, 1'b1, 1'b0, 30);
        for (int p = 0; p < 100; p++) @(negedge clk);
        check("pre_reset_playing", playing, 1'b1);
        rst_b = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        @(negedge clk);
        reset_and_release();

        // INIT restarts; a press during INIT waits for INIT to finish
        repeat (2) run_frame(1'b0, 1'b0, 1'b0, 0);
        run_frame(1'b1, 1'b1, 1'b0, 40);
        repeat (6) run_frame(1'b1, 1'b0, 1'b0, 0);

        // Let the last expected frame drain
        sdin = 1'b1;
        repeat (256) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("frames_seen", mon_frames, frames_sent - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
